// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the next-PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_seq_state_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

endpackage

// File: rtl/pc_target_sel.sv
// Combinational next-PC target selection: halt > jump > branch > sequential.
// Flags a misaligned jump/branch target; halt and sequential steps never trap.
module pc_target_sel
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc_out,
  input  logic        halt_req,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] target,
  output logic        misaligned
);

  always_comb begin
    target     = pc_out + PC_STEP;
    misaligned = 1'b0;
    if (halt_req) begin
      target     = pc_out + PC_STEP;
      misaligned = 1'b0;
    end else if (jump) begin
      target     = jump_target;
      misaligned = |jump_target[1:0];
    end else if (branch_taken) begin
      target     = branch_target;
      misaligned = |branch_target[1:0];
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: BOOT/RUN/HALT FSM, trap/epc registers, retire counter.
// Optional retired-instruction counter enabled by defining PC_SEQ_INSTRET_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_out,
  output logic [31:0] PC_in,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic        retire,
  output logic        trap,
  output logic [31:0] epc,
  output logic [1:0]  seq_state,
  output logic [31:0] instret
);

  pc_seq_state_t state, state_next;
  logic [31:0]   sel_target;
  logic          sel_misaligned;
  logic          take_trap;

  pc_target_sel u_target_sel (
    .pc_out        (PC_out),
    .halt_req      (halt_req),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .target        (sel_target),
    .misaligned    (sel_misaligned)
  );

  // Fetch handshake: imem_req is held high with PC_out stable until a cycle
  // with imem_ready=1 and stall=0; that cycle retires and PC_in advances.
  always_comb begin
    state_next = state;
    PC_in      = PC_out;
    imem_req   = 1'b0;
    retire     = 1'b0;
    take_trap  = 1'b0;
    case (state)
      BOOT: begin
        PC_in      = RESET_VECTOR;
        state_next = RUN;
      end
      RUN: begin
        imem_req = 1'b1;
        retire   = imem_ready & ~stall;
        if (retire) begin
          take_trap = sel_misaligned;
          PC_in     = sel_misaligned ? TRAP_VECTOR : sel_target;
          if (halt_req) state_next = HALT;
        end
      end
      HALT: begin
        if (resume) state_next = RUN;
      end
      default: begin
        PC_in      = RESET_VECTOR;
        state_next = BOOT;
      end
    endcase
    if (reset) begin
      PC_in      = RESET_VECTOR;
      imem_req   = 1'b0;
      retire     = 1'b0;
      take_trap  = 1'b0;
      state_next = BOOT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      trap  <= 1'b0;
      epc   <= 32'd0;
    end else begin
      state <= state_next;
      trap  <= take_trap;
      if (take_trap) epc <= PC_out;
    end
  end

  assign seq_state = state;

`ifdef PC_SEQ_INSTRET_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (reset) instret_q <= 32'd0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = 32'd0;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the single-cycle core. It drives `PC_in` of the existing program counter register and reads back `PC_out`. It paces instruction fetch with a ready handshake, and resolves stall, jump, branch and halt requests into one next-PC per cycle. It also redirects misaligned control-flow targets to a trap vector.

## Interface
- `RESET_VECTOR`, 32'h0000_0000: first fetch address after reset.
- `TRAP_VECTOR`, 32'h0000_0100: redirect address for a misaligned jump/branch target.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `PC_out`  in  32  current PC from the program counter register. That register loads `PC_in` every edge and clears to 0 on `reset`.
- `PC_in`  out  32  next PC (combinational).
- `imem_req`  out  1  fetch request for the instruction at `PC_out`.
- `imem_ready`  in  1  instruction memory has returned the word for `PC_out`.
- `stall`  in  1  datapath hold; blocks retirement.
- `jump`  in  1  current instruction is an unconditional jump.
- `jump_target`  in  32  jump destination.
- `branch_taken`  in  1  current instruction is a taken branch.
- `branch_target`  in  32  branch destination.
- `halt_req`  in  1  current instruction is ebreak/halt.
- `resume`  in  1  leave HALT.
- `retire`  out  1  current instruction completes this cycle (combinational).
- `trap`  out  1  registered one-cycle pulse after a misaligned redirect.
- `epc`  out  32  registered PC of the last trapping instruction.
- `seq_state`  out  2  registered FSM state.
- `instret`  out  32  registered retired-instruction count.

## Operation
- States:
  - BOOT=0: `PC_in`=`RESET_VECTOR`; `imem_req`=0. Always goes to RUN next cycle.
  - RUN=1: normal fetch and retire.
  - HALT=2: hold PC; no fetch.
  - Encoding 3 is unused and recovers to BOOT.
- RUN:
  - `imem_req`=1.
  - `retire` = `imem_ready` & !`stall`.
  - Without retire: `PC_in`=`PC_out` (hold).
- Next PC at retire, highest priority first:
  - `halt_req`: `PC_in`=`PC_out`+4; state becomes HALT. Jump and branch are ignored.
  - `jump`: `PC_in`=`jump_target`.
  - `branch_taken`: `PC_in`=`branch_target`.
  - Otherwise: `PC_in`=`PC_out`+4.
- Misaligned target: the selected jump or branch target has bits [1:0] != 0.
  - `PC_in`=`TRAP_VECTOR`.
  - `epc`<=`PC_out`; `trap`<=1 for one cycle.
  - The instruction still counts as retired.
- HALT:
  - `PC_in`=`PC_out`; `imem_req`=0; `retire`=0.
  - `resume` moves to RUN next cycle. `halt_req` is ignored in HALT.
- Arithmetic is modulo 2^32: `PC_out`=32'hFFFF_FFFC with a sequential retire gives `PC_in`=0, no trap. `instret` wraps to 0.

## Timing
- Values while `reset`=1: `PC_in`=`RESET_VECTOR`, `imem_req`=0, `retire`=0.
- Register values after the first reset edge: `seq_state`=BOOT, `instret`=0, `trap`=0, `epc`=0.
- Reset mid-operation (any state, any pending handshake) aborts to BOOT. The fetch in flight is dropped and not counted.
- First fetch:
  - The cycle after reset deasserts is BOOT.
  - On the next edge `PC_out`=`RESET_VECTOR` and the state is RUN, with `imem_req`=1.
- Latency: `PC_in` is valid the same cycle as `imem_ready`. `PC_out` updates on the following edge, so zero wait states gives one retire per cycle.
- Wait states: `imem_req` stays high and `PC_out` stays stable until `imem_ready`=1 with `stall`=0.
- Same-cycle `stall` and `imem_ready`: no retire; the handshake repeats next cycle.
- `instret` increments on the edge closing each retire cycle. `trap` is high during the cycle after the redirect.

## Configuration
- `PC_SEQ_INSTRET_EN`:
  - Defined: the 32-bit `instret` counter is implemented.
  - Undefined: `instret` is tied to 0 and no counter flops exist. All other behaviour is identical.

## Structure
- Package `pc_seq_pkg` holds:
  - `pc_seq_state_t` enum (BOOT, RUN, HALT).
  - `PC_STEP`=4.
  - Default `RESET_VECTOR_DEF` and `TRAP_VECTOR_DEF`.
- Sub-module `pc_target_sel`, combinational:
  - Inputs: `PC_out`, jump/branch/halt controls and targets.
  - Outputs: selected target and misaligned flag.
- The top level keeps the FSM, `trap`/`epc` registers and counter.
- The bench instantiates `pc_sequencer` together with the program counter register, closing the `PC_in`/`PC_out` loop.

## Test plan
- Boot, sequential run:
  - Stimulus: reset 2 cycles, then `imem_ready`=1 constantly.
  - Required: `PC_out` steps 0, 4, 8, 12; `instret`=4 after 4 retires.
- Wait states:
  - Stimulus: `imem_ready` low for 3 cycles at `PC_out`=8.
  - Required: `PC_in`=8 held; `imem_req`=1 throughout; `instret` unchanged until ready.
- Redirect priority:
  - Stimulus: `jump`=1 to 0x40 and `branch_taken`=1 to 0x80 in the same cycle.
  - Required: next `PC_out`=0x40.
  - Stimulus: `stall`=1 with ready.
  - Required: hold, no retire.
- Misaligned trap:
  - Stimulus: `branch_taken`=1, `branch_target`=0x22 at `PC_out`=0x10.
  - Required: next `PC_out`=0x100; `trap` pulses once; `epc`=0x10.
- Halt and resume:
  - Stimulus: `halt_req` together with `jump` at `PC_out`=0x20.
  - Required: `PC_out`=0x24, state HALT, `imem_req`=0.
  - Stimulus: `resume`.
  - Required: RUN on the next edge, fetch at 0x24.
- Wrap and reset mid-wait:
  - Stimulus: `PC_out`=0xFFFF_FFFC with a sequential retire.
  - Required: next `PC_out`=0.
  - Stimulus: `reset` asserted during a wait.
  - Required: BOOT, then `PC_out`=`RESET_VECTOR`.
